vga_scale_funcmod: RTL and testbench
====================================

Name: vga_scale_funcmod

Overview:
Parametrised VGA timing and pixel-fetch engine; successor to the fixed 640x480/320x240 timing block. Generates HSYNC/VSYNC with programmable timing and polarity, and places an XSIZE x YSIZE source image at a programmable offset. Each source pixel is replicated 2^SCALE_LOG2 times horizontally and vertically. Sits between the frame-buffer/line-buffer savemod, which it drives with a read address, enable and line-request tag, and the VGA DAC pins.

Parameters:
DW, 16, pixel data width
HSW, 96, hsync width (clocks)
HBP, 48, h back porch
HACT, 640, h active pixels
HFP, 16, h front porch; HT = HSW+HBP+HACT+HFP
VSW, 2, vsync width (lines)
VBP, 33, v back porch
VACT, 480, v active lines
VFP, 10, v front porch; VT = VSW+VBP+VACT+VFP
HPOL, 0, hsync asserted level
VPOL, 0, vsync asserted level
XSIZE, 320, source image width
YSIZE, 240, source image height
XOFF, 0, window x offset (display pixels, from start of active)
YOFF, 0, window y offset (display lines)
SCALE_LOG2, 1, replication factor exponent (0..3)
FRAME_DELAY, 60, frames to wait after reset before output enables (0 = immediate)
BG, 0, DW-bit colour inside active area but outside window

Ports:
CLOCK  in  1  pixel clock
RESET  in  1  synchronous, active-high reset
VGA_HSYNC  out  1  horizontal sync, pipeline-aligned with VGAD
VGA_VSYNC  out  1  vertical sync, pipeline-aligned with VGAD
VGAD  out  DW  pixel colour
oDE  out  1  display enable (active area), aligned with VGAD
oEn  out  1  read enable to savemod
oAddr  out  11  source x address, valid when oEn=1
iData  in  DW  pixel from savemod, valid 1 clock after oEn/oAddr
oTag  out  11  [10] line-request pulse, [9:0] source row number

Behaviour:
- Reset: one clock, single shared clock domain. Synchronous active-high RESET; takes effect on the next CLOCK edge, including mid-frame.
- Reset values: CH=0, CV=0, frame counter=0, isON=0, VGAD=0, oDE=0, oEn=0, oAddr=0, oTag=0. VGA_HSYNC=!HPOL and VGA_VSYNC=!VPOL (deasserted).
- Counters: CH runs 0..HT-1 and wraps. CV increments when CH==HT-1 and wraps to 0 when CV==VT-1 && CH==HT-1.
- Stage 0 (combinational on counters):
  - hs = CH<HSW; vs = CV<VSW.
  - act = CH in [HSW+HBP, HSW+HBP+HACT) && CV in [VSW+VBP, VSW+VBP+VACT).
  - hx = CH-(HSW+HBP); vy = CV-(VSW+VBP).
  - win = act && isON && hx in [XOFF, XOFF+(XSIZE<<S)) && vy in [YOFF, YOFF+(YSIZE<<S)).
- Stage 1 (registered): oEn=win; oAddr=(hx-XOFF)>>S.
- Stage 2: iData valid.
- Stage 3 (registered):
  - VGAD = iData if the stage-2 win copy is set; BG if stage-2 act && isON; else 0.
  - oDE = act (delayed).
  - Syncs = hs/vs delayed 3 clocks, mapped through HPOL/VPOL.
- Total latency counter to pins: 3 clocks, identical for VGAD, oDE, VGA_HSYNC and VGA_VSYNC.
- Line request (prefetch one line ahead):
  - oTag[10] pulses for exactly 1 clock at CH==0 of line CV when line CV+1 lies in the window rows and (vy+1-YOFF) mod 2^S == 0.
  - oTag[9:0] = (vy+1-YOFF)>>S, updated in the same cycle as the pulse and held until the next pulse.
  - The request for source row 0 is issued on the line before the window starts.
- Power-up delay:
  - Frame counter increments at the CV==VT-1 && CH==HT-1 end-of-frame while isON=0.
  - When it equals FRAME_DELAY, isON is set and remains 1 until RESET. The counter saturates.
  - Output therefore starts at the beginning of frame FRAME_DELAY.
  - While isON=0: syncs run; VGAD=0, oEn=0, no tags.
- Clipping: window parts outside the active area are never fetched or displayed. oAddr and oTag are never emitted for clipped pixels.
- Replication: each source pixel is fetched on 2^S consecutive clocks (same oAddr) and on 2^S consecutive lines.
- Width: all counters 11 bits; window compare done in 12 bits to avoid wrap with large offsets.

Test Plan:
- Defaults, FRAME_DELAY=0: after reset, VGA_HSYNC low for CH 0..95 delayed 3 clocks. Line period 800 clocks, frame 525 lines, VGA_VSYNC low for lines 0..1.
- FRAME_DELAY=2: VGAD=0 and oEn=0 throughout frames 0 and 1. First oEn occurs in frame 2 at line 35, CH=144.
- SCALE_LOG2=1, savemod model returns iData=oAddr: line 35 VGAD sequence is 0,0,1,1,2,2...319,319 starting 3 clocks after CH=144. oDE is high for exactly 640 clocks.
- Tags, defaults: oTag[10] pulses at CH=0 of lines 34,36,...,512 with rows 0,1,...,239. That is 240 pulses per frame, each 1 clock wide.
- XOFF=600, YOFF=470, SCALE_LOG2=0: only hx 600..639 and lines vy 470..479 are fetched, with oAddr 0..39. BG is shown elsewhere in the active area. Rows 0..9 are requested.
- RESET asserted mid-line (CH=300, CV=200) for 1 clock: next cycle CH=0, CV=0, isON=0, all outputs at reset values. The frame delay restarts.

Source files
------------

// File: rtl/vga_scale_funcmod.sv
// VGA timing generator with a scaled, offset source-image window and savemod line prefetch.
// Counter-to-pin latency is 3 clocks for colour, DE and both syncs.
module vga_scale_funcmod #(
    parameter int             DW          = 16,
    parameter int             HSW         = 96,
    parameter int             HBP         = 48,
    parameter int             HACT        = 640,
    parameter int             HFP         = 16,
    parameter int             VSW         = 2,
    parameter int             VBP         = 33,
    parameter int             VACT        = 480,
    parameter int             VFP         = 10,
    parameter int             HPOL        = 0,
    parameter int             VPOL        = 0,
    parameter int             XSIZE       = 320,
    parameter int             YSIZE       = 240,
    parameter int             XOFF        = 0,
    parameter int             YOFF        = 0,
    parameter int             SCALE_LOG2  = 1,
    parameter int             FRAME_DELAY = 60,
    parameter logic [DW-1:0]  BG          = '0
) (
    input  logic          CLOCK,
    input  logic          RESET,
    output logic          VGA_HSYNC,
    output logic          VGA_VSYNC,
    output logic [DW-1:0] VGAD,
    output logic          oDE,
    output logic          oEn,
    output logic [10:0]   oAddr,
    input  logic [DW-1:0] iData,
    output logic [10:0]   oTag
);

    localparam int HT = HSW + HBP + HACT + HFP;
    localparam int VT = VSW + VBP + VACT + VFP;

    localparam logic [10:0] HT_M1 = 11'(HT - 1);
    localparam logic [10:0] VT_M1 = 11'(VT - 1);
    localparam logic [10:0] FD_C  = 11'(FRAME_DELAY);

    // Window bounds are compared in 12 bits so large offsets cannot wrap.
    localparam logic [11:0] HS_E  = 12'(HSW);
    localparam logic [11:0] VS_E  = 12'(VSW);
    localparam logic [11:0] HA0   = 12'(HSW + HBP);
    localparam logic [11:0] HA1   = 12'(HSW + HBP + HACT);
    localparam logic [11:0] VA0   = 12'(VSW + VBP);
    localparam logic [11:0] VA1   = 12'(VSW + VBP + VACT);
    localparam logic [11:0] WX0   = 12'(XOFF);
    localparam logic [11:0] WX1   = 12'(XOFF + (XSIZE << SCALE_LOG2));
    localparam logic [11:0] WY0   = 12'(YOFF);
    localparam logic [11:0] WY1   = 12'(YOFF + (YSIZE << SCALE_LOG2));
    localparam logic [11:0] REP_M = 12'((1 << SCALE_LOG2) - 1);

    localparam logic HP = (HPOL != 0);
    localparam logic VP = (VPOL != 0);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic bg;
        logic win;
    } ctl_t;

    logic [10:0] ch_q, ch_d;
    logic [10:0] cv_q, cv_d;
    logic [10:0] fcnt_q, fcnt_d;
    logic        on_q, on_d;
    logic        eol, eof;

    ctl_t        s0;
    ctl_t [2:1]  ctl_q;
    logic [11:0] ch12, cv12, hx, vy, xrel;
    logic [11:0] nl, ny, nyo;
    logic        req0;

    logic          en_q;
    logic [10:0]   addr_q;
    logic [10:0]   tag_q;
    logic [DW-1:0] pix_q;
    logic          de_q, hsync_q, vsync_q;

    // Raster counters and power-up frame delay
    always_comb begin
        eol    = (ch_q == HT_M1);
        eof    = eol && (cv_q == VT_M1);
        ch_d   = eol ? 11'd0 : ch_q + 11'd1;
        cv_d   = eof ? 11'd0 : (eol ? cv_q + 11'd1 : cv_q);
        fcnt_d = fcnt_q;
        if (eof && !on_q && (fcnt_q != 11'h7FF))
            fcnt_d = fcnt_q + 11'd1;
        on_d   = on_q | (fcnt_q == FD_C);
    end

    // Stage 0: decode counters into sync, active, window and line-request terms
    always_comb begin
        ch12   = {1'b0, ch_q};
        cv12   = {1'b0, cv_q};
        hx     = ch12 - HA0;
        vy     = cv12 - VA0;
        xrel   = hx - WX0;
        s0.hs  = (ch12 < HS_E);
        s0.vs  = (cv12 < VS_E);
        s0.act = (ch12 >= HA0) && (ch12 < HA1) && (cv12 >= VA0) && (cv12 < VA1);
        s0.bg  = s0.act && on_q;
        s0.win = s0.bg && (hx >= WX0) && (hx < WX1) && (vy >= WY0) && (vy < WY1);
        // Request is for the next line; only the first of each replicated row group asks.
        nl     = cv12 + 12'd1;
        ny     = nl - VA0;
        nyo    = ny - WY0;
        req0   = on_q && (ch_q == 11'd0) && (nl >= VA0) && (nl < VA1) &&
                 (ny >= WY0) && (ny < WY1) && ((nyo & REP_M) == 12'd0);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ch_q    <= '0;
            cv_q    <= '0;
            fcnt_q  <= '0;
            on_q    <= 1'b0;
            ctl_q   <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
            pix_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~HP;
            vsync_q <= ~VP;
        end else begin
            ch_q     <= ch_d;
            cv_q     <= cv_d;
            fcnt_q   <= fcnt_d;
            on_q     <= on_d;
            ctl_q[1] <= s0;
            ctl_q[2] <= ctl_q[1];
            en_q     <= s0.win;
            if (s0.win)
                addr_q <= 11'(xrel >> SCALE_LOG2);
            tag_q[10] <= req0;
            if (req0)
                tag_q[9:0] <= 10'(nyo >> SCALE_LOG2);
            // Stage 3: iData belongs to the fetch issued one clock earlier.
            if (ctl_q[2].win)
                pix_q <= iData;
            else if (ctl_q[2].bg)
                pix_q <= BG;
            else
                pix_q <= '0;
            de_q    <= ctl_q[2].act;
            hsync_q <= ctl_q[2].hs ? HP : ~HP;
            vsync_q <= ctl_q[2].vs ? VP : ~VP;
        end
    end

    assign VGA_HSYNC = hsync_q;
    assign VGA_VSYNC = vsync_q;
    assign VGAD      = pix_q;
    assign oDE       = de_q;
    assign oEn       = en_q;
    assign oAddr     = addr_q;
    assign oTag      = tag_q;

endmodule

// File: tb/tb_vga_scale_funcmod.sv
// Random-reset bench for vga_scale_funcmod on a shrunken raster, checked every clock
// against a time-indexed model of the raster, window, fetch and line-request rules.
module tb_vga_scale_funcmod;

    localparam int DW = 16;
    localparam int HSW = 4, HBP = 3, HACT = 20, HFP = 2;
    localparam int VSW = 2, VBP = 2, VACT = 12, VFP = 2;
    localparam int HPOL = 1, VPOL = 0;
    localparam int XSIZE = 7, YSIZE = 4, XOFF = 9, YOFF = 6, S = 1, FD = 2;
    localparam logic [DW-1:0] BGC = 16'h5A5A;
    localparam int HT = HSW + HBP + HACT + HFP;
    localparam int VT = VSW + VBP + VACT + VFP;
    localparam int FR = HT * VT;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic [DW-1:0] iData = '0;
    logic          VGA_HSYNC, VGA_VSYNC, oDE, oEn;
    logic [DW-1:0] VGAD;
    logic [10:0]   oAddr, oTag;

    int            checks = 0;
    int            errors = 0;
    int            k = 0;
    bit            armed = 0;
    logic [DW-1:0] xs [XSIZE];
    logic [DW-1:0] pend = '0;
    logic [9:0]    exp_row = '0;

    always #5 CLOCK = ~CLOCK;

    vga_scale_funcmod #(
        .DW(DW), .HSW(HSW), .HBP(HBP), .HACT(HACT), .HFP(HFP),
        .VSW(VSW), .VBP(VBP), .VACT(VACT), .VFP(VFP),
        .HPOL(HPOL), .VPOL(VPOL), .XSIZE(XSIZE), .YSIZE(YSIZE),
        .XOFF(XOFF), .YOFF(YOFF), .SCALE_LOG2(S), .FRAME_DELAY(FD), .BG(BGC)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
        .VGAD(VGAD), .oDE(oDE), .oEn(oEn), .oAddr(oAddr),
        .iData(iData), .oTag(oTag)
    );

    // t = clocks since the last reset edge; negative t means the pipeline still holds reset state.
    function automatic int f_ch(int t); return t % HT; endfunction
    function automatic int f_cv(int t); return (t / HT) % VT; endfunction
    function automatic bit f_on(int t); return t >= 0 && (t / FR) >= FD; endfunction
    function automatic bit f_hs(int t); return t >= 0 && f_ch(t) < HSW; endfunction
    function automatic bit f_vs(int t); return t >= 0 && f_cv(t) < VSW; endfunction

    function automatic bit f_act(int t);
        int ch, cv;
        if (t < 0) return 0;
        ch = f_ch(t); cv = f_cv(t);
        return ch >= HSW + HBP && ch < HSW + HBP + HACT && cv >= VSW + VBP && cv < VSW + VBP + VACT;
    endfunction

    function automatic bit f_win(int t);
        int hx, vy;
        hx = f_ch(t) - (HSW + HBP);
        vy = f_cv(t) - (VSW + VBP);
        return f_act(t) && f_on(t) && hx >= XOFF && hx < XOFF + XSIZE * (1 << S) &&
               vy >= YOFF && vy < YOFF + YSIZE * (1 << S);
    endfunction

    function automatic int f_x(int t);
        return (f_ch(t) - (HSW + HBP) - XOFF) / (1 << S);
    endfunction

    function automatic int f_ny(int t);
        return f_cv(t) + 1 - (VSW + VBP);
    endfunction

    function automatic bit f_req(int t);
        int ny;
        if (t < 0 || !f_on(t) || f_ch(t) != 0) return 0;
        ny = f_ny(t);
        return ny >= 0 && ny < VACT && ny >= YOFF && ny < YOFF + YSIZE * (1 << S) &&
               ((ny - YOFF) % (1 << S)) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_cycle();
        int t1, t3;
        logic [DW-1:0] pix;
        t1 = k - 1;
        t3 = k - 3;
        if (f_req(t1))
            exp_row = 10'((f_ny(t1) - YOFF) / (1 << S));
        chk("hsync", 32'(VGA_HSYNC), 32'(f_hs(t3) ? HPOL[0] : !HPOL[0]));
        chk("vsync", 32'(VGA_VSYNC), 32'(f_vs(t3) ? VPOL[0] : !VPOL[0]));
        chk("de", 32'(oDE), 32'(f_act(t3)));
        if (f_win(t3))         pix = xs[f_x(t3)];
        else if (f_act(t3) && f_on(t3)) pix = BGC;
        else                   pix = '0;
        chk("vgad", 32'(VGAD), 32'(pix));
        chk("en", 32'(oEn), 32'(f_win(t1)));
        if (f_win(t1)) chk("addr", 32'(oAddr), 32'(f_x(t1)));
        if (k == 0)    chk("addr_rst", 32'(oAddr), 32'd0);
        chk("tag_req", 32'(oTag[10]), 32'(f_req(t1)));
        chk("tag_row", 32'(oTag[9:0]), 32'(exp_row));
    endtask

    // One clock: drive RESET for the coming edge, then check after it, then model savemod.
    task automatic step(input bit rst);
        RESET = rst;
        @(posedge CLOCK);
        if (RESET) begin
            k = 0;
            armed = 1;
            exp_row = '0;
        end else begin
            k++;
        end
        #1 iData = pend;
        @(negedge CLOCK);
        if (armed) check_cycle();
        if (oEn === 1'b1 && int'(oAddr) < XSIZE) pend = xs[int'(oAddr)];
        else                                     pend = DW'($urandom);
    endtask

    initial begin
        for (int i = 0; i < XSIZE; i++) xs[i] = DW'($urandom);
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 4 * FR; i++) step(1'b0);
        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(50, 2 * FR));
            for (int i = 0; i < n; i++) step(1'b0);
            step(1'b1);
        end
        for (int i = 0; i < 3 * FR + 10; i++) step(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
